// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: data + control word with valid/ready handshake,
// hazard stall, bubble-inserting flush, optional 2-entry skid buffer and
// saturating stall/flush event counters for CPI debug.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned SKID       = 0,
  parameter int unsigned FLUSH_DATA = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic              emit;
  logic              accept;
  logic              main_free;
  logic [1:0]        drop_cnt;
  logic [CNT_W:0]    stall_sum;
  logic [CNT_W:0]    flush_sum;

  // Handshake: with the skid buffer, in_ready depends only on registered state.
  always_comb begin
    emit      = main_v_q & out_ready;
    main_free = ~main_v_q | emit;
    if (SKID != 0) begin
      in_ready = ~stall & ~skid_v_q;
    end else begin
      in_ready = ~stall & (~main_v_q | out_ready);
    end
    accept = in_valid & in_ready;
  end

  // Next state of main/skid entries, including flush bubbles and drop counting.
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    drop_cnt    = 2'd0;

    if (main_free) begin
      // Skid (older) refills main first; skid full implies no accept this cycle.
      skid_v_d = 1'b0;
      if (flush || !(skid_v_q || accept)) begin
        // Bubble: ctrl always cleared so out_valid=0 never carries live ctrl.
        main_v_d    = 1'b0;
        main_ctrl_d = '0;
        if (FLUSH_DATA != 0) begin
          main_data_d = '0;
        end
        drop_cnt = {1'b0, skid_v_q | accept};
      end else if (skid_v_q) begin
        main_v_d    = 1'b1;
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
      end else begin
        main_v_d    = 1'b1;
        main_data_d = in_data;
        main_ctrl_d = in_ctrl;
      end
    end else if (flush) begin
      // Held main entry is older than the branch and survives; younger ones go.
      skid_v_d = 1'b0;
      drop_cnt = {1'b0, skid_v_q} + {1'b0, accept};
    end else if (accept) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data;
      skid_ctrl_d = in_ctrl;
    end
  end

  // Saturating event counters.
  always_comb begin
    stall_sum   = {1'b0, stall_cnt_q} + (CNT_W + 1)'(in_valid & ~in_ready);
    flush_sum   = {1'b0, flush_cnt_q} + (CNT_W + 1)'(drop_cnt);
    stall_cnt_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    flush_cnt_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances share one input stream
//   dut0: SKID=0 FLUSH_DATA=1 CNT_W=16
//   dut1: SKID=1 FLUSH_DATA=1 CNT_W=16
//   dut2: SKID=0 FLUSH_DATA=0 CNT_W=2
// Each instance has an occupancy-list reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, out_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;

  logic        iready[3];
  logic        ov[3];
  logic [31:0] od[3];
  logic [15:0] oc[3];
  logic [15:0] sc[3];
  logic [15:0] fc[3];
  logic [1:0]  sc2, fc2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .FLUSH_DATA(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[0]), .in_data(in_data),
    .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0])
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .FLUSH_DATA(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[1]), .in_data(in_data),
    .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1])
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .FLUSH_DATA(0), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[2]), .in_data(in_data),
    .in_ctrl(in_ctrl), .stall(stall), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_ctrl(oc[2]), .stall_cnt(sc2), .flush_cnt(fc2)
  );

  assign sc[2] = {14'd0, sc2};
  assign fc[2] = {14'd0, fc2};

  // Reference model: ordered list of held entries (index 0 = oldest = at output).
  bit          skid_p[3]  = '{1'b0, 1'b1, 1'b0};
  bit          fdata_p[3] = '{1'b1, 1'b1, 1'b0};
  int unsigned cmax[3]    = '{32'd65535, 32'd65535, 32'd3};
  int          m_n[3];
  logic [31:0] m_d[3][2];
  logic [15:0] m_c[3][2];
  int unsigned m_sc[3];
  int unsigned m_fc[3];
  logic [31:0] m_last[3];
  bit          m_chk[3];

  function automatic bit mready(input int k);
    if (skid_p[k]) return !stall && (m_n[k] < 2);
    return !stall && (m_n[k] == 0 || out_ready);
  endfunction

  task automatic model_step(input int k);
    bit rdy, emit, acc, bubble;
    int keep, dropped;
    if (rst) begin
      m_n[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_last[k] = '0; m_chk[k] = 1'b1;
      return;
    end
    rdy    = mready(k);
    emit   = (m_n[k] > 0) && out_ready;
    acc    = in_valid && rdy;
    bubble = 1'b0;
    if (in_valid && !rdy && m_sc[k] < cmax[k]) m_sc[k]++;
    keep = (!emit && m_n[k] > 0) ? 1 : 0;
    if (emit) begin
      m_d[k][0] = m_d[k][1];
      m_c[k][0] = m_c[k][1];
      m_n[k]--;
    end
    if (flush) begin
      dropped = m_n[k] - keep + (acc ? 1 : 0);
      m_n[k]  = keep;
      m_fc[k] = (m_fc[k] + dropped > cmax[k]) ? cmax[k] : m_fc[k] + dropped;
      if (keep == 0 && dropped > 0) begin
        bubble = 1'b1;
        if (fdata_p[k]) m_last[k] = '0;
      end
    end else if (acc) begin
      m_d[k][m_n[k]] = in_data;
      m_c[k][m_n[k]] = in_ctrl;
      m_n[k]++;
    end
    if (m_n[k] > 0) begin
      m_last[k] = m_d[k][0];
      m_chk[k]  = 1'b1;
    end else begin
      m_chk[k] = bubble;
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = 32'hDEADBEEF;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nvec++; if (ov[k] !== 1'b0) begin nerr++; $display("FAIL reset_valid dut%0d got %0b want 0", k, ov[k]); end
      nvec++; if (oc[k] !== 16'h0) begin nerr++; $display("FAIL reset_ctrl dut%0d got %h want 0", k, oc[k]); end
      nvec++; if (od[k] !== 32'h0) begin nerr++; $display("FAIL reset_data dut%0d got %h want 0", k, od[k]); end
      nvec++; if (sc[k] !== 16'h0) begin nerr++; $display("FAIL reset_stall_cnt dut%0d got %0d want 0", k, sc[k]); end
      nvec++; if (fc[k] !== 16'h0) begin nerr++; $display("FAIL reset_flush_cnt dut%0d got %0d want 0", k, fc[k]); end
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_ctrl = 16'(i);
      #1;
      for (int k = 0; k < 2; k++) begin
        nvec++; if (iready[k] !== 1'b1) begin nerr++; $display("FAIL stream_ready dut%0d got %0b want 1", k, iready[k]); end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        nvec++;
        if (ov[k] !== 1'b1 || od[k] !== 32'(i)) begin
          nerr++; $display("FAIL stream_out dut%0d got v=%0b d=%0d want v=1 d=%0d", k, ov[k], od[k], i);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    nvec++; if (ov[0] !== 1'b0) begin nerr++; $display("FAIL stream_drain got %0b want 0", ov[0]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] seen[$];
    bit acc_c;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0A0A;
    in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_data = 32'hC; #1;
    nvec++; if (iready[1] !== 1'b0) begin nerr++; $display("FAIL bp_ready_full got %0b want 0", iready[1]); end
    tick();
    out_ready = 1'b1; acc_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 0) begin
        // Skid still full this cycle: ready must not follow out_ready combinationally.
        nvec++; if (iready[1] !== 1'b0) begin nerr++; $display("FAIL bp_ready_registered got %0b want 0", iready[1]); end
      end
      if (ov[1] && out_ready) seen.push_back(od[1]);
      if (in_valid && iready[1]) acc_c = 1'b1;
      tick();
      if (acc_c) in_valid = 1'b0;
    end
    nvec++; if (!acc_c) begin nerr++; $display("FAIL bp_c_accepted got 0 want 1"); end
    nvec++;
    if (seen.size() != 3) begin
      nerr++; $display("FAIL bp_count got %0d want 3", seen.size());
    end else if (seen[0] !== 32'hA || seen[1] !== 32'hB || seen[2] !== 32'hC) begin
      nerr++; $display("FAIL bp_order got %h %h %h want a b c", seen[0], seen[1], seen[2]);
    end
    nvec++; if (sc[1] !== 16'd2) begin nerr++; $display("FAIL bp_stall_cnt got %0d want 2", sc[1]); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h00F0;
    in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_data = 32'hC; flush = 1'b1; #1;
    nvec++; if (iready[1] !== 1'b0) begin nerr++; $display("FAIL flush_ready1 got %0b want 0", iready[1]); end
    tick();
    nvec++; if (fc[1] !== 16'd1) begin nerr++; $display("FAIL flush_cnt_skid got %0d want 1", fc[1]); end
    #1;
    // Skid discarded, so C is now accepted and, with flush still high, dropped.
    nvec++; if (iready[1] !== 1'b1) begin nerr++; $display("FAIL flush_ready2 got %0b want 1", iready[1]); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    nvec++; if (fc[1] !== 16'd2) begin nerr++; $display("FAIL flush_cnt got %0d want 2", fc[1]); end
    nvec++;
    if (ov[1] !== 1'b1 || od[1] !== 32'hA) begin
      nerr++; $display("FAIL flush_keep_main got v=%0b d=%h want v=1 d=a", ov[1], od[1]);
    end
    out_ready = 1'b1;
    tick();
    nvec++;
    if (ov[1] !== 1'b0 || oc[1] !== 16'h0) begin
      nerr++; $display("FAIL flush_after_a got v=%0b c=%h want v=0 c=0", ov[1], oc[1]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'h1;
    tick();
    stall = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nvec++; if (iready[0] !== 1'b0) begin nerr++; $display("FAIL stall_ready got %0b want 0", iready[0]); end
      tick();
      if (i == 0) begin
        nvec++; if (ov[0] !== 1'b0) begin nerr++; $display("FAIL stall_drain got %0b want 0", ov[0]); end
      end
    end
    nvec++; if (sc[0] !== 16'd4) begin nerr++; $display("FAIL stall_cnt got %0d want 4", sc[0]); end
    stall = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    stall = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      nvec++;
      if (sc[2] !== 16'((i > 3) ? 3 : i)) begin
        nerr++; $display("FAIL sat_stall_cnt cycle%0d got %0d want %0d", i, sc[2], (i > 3) ? 3 : i);
      end
    end
    stall = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_flush_bubble();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h1234; in_ctrl = 16'h0055;
    tick();
    nvec++; if (ov[2] !== 1'b1 || od[2] !== 32'h1234) begin nerr++; $display("FAIL bubble_load got v=%0b d=%h want v=1 d=1234", ov[2], od[2]); end
    in_data = 32'h5678; in_ctrl = 16'h0066; flush = 1'b1;
    tick();
    nvec++;
    if (ov[2] !== 1'b0 || oc[2] !== 16'h0 || od[2] !== 32'h1234) begin
      nerr++; $display("FAIL bubble_keepdata got v=%0b c=%h d=%h want v=0 c=0 d=1234", ov[2], oc[2], od[2]);
    end
    nvec++;
    if (ov[0] !== 1'b0 || oc[0] !== 16'h0 || od[0] !== 32'h0) begin
      nerr++; $display("FAIL bubble_zerodata got v=%0b c=%h d=%h want v=0 c=0 d=0", ov[0], oc[0], od[0]);
    end
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b0; in_valid = 1'b0;
    nvec++; if (fc[0] !== 16'd4) begin nerr++; $display("FAIL bubble_flush_cnt got %0d want 4", fc[0]); end
    nvec++; if (fc[2] !== 16'd3) begin nerr++; $display("FAIL sat_flush_cnt got %0d want 3", fc[2]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      in_data   = $urandom;
      in_ctrl   = 16'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (iready[k] !== mready(k)) begin
          nerr++; $display("FAIL rnd_ready dut%0d cyc%0d got %0b want %0b", k, n, iready[k], mready(k));
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (ov[k] !== (m_n[k] > 0) || oc[k] !== ((m_n[k] > 0) ? m_c[k][0] : 16'h0)) begin
          nerr++; $display("FAIL rnd_out dut%0d cyc%0d got v=%0b c=%h want v=%0b c=%h", k, n, ov[k], oc[k],
                           m_n[k] > 0, (m_n[k] > 0) ? m_c[k][0] : 16'h0);
        end
        if (m_chk[k]) begin
          nvec++;
          if (od[k] !== m_last[k]) begin
            nerr++; $display("FAIL rnd_data dut%0d cyc%0d got %h want %h", k, n, od[k], m_last[k]);
          end
        end
        nvec++;
        if (sc[k] !== 16'(m_sc[k]) || fc[k] !== 16'(m_fc[k])) begin
          nerr++; $display("FAIL rnd_cnt dut%0d cyc%0d got s=%0d f=%0d want s=%0d f=%0d", k, n, sc[k], fc[k],
                           m_sc[k], m_fc[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall();
    test_saturation();
    test_flush_bubble();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
